// File: rtl/vga_timing_generator.sv
// 640x480@60 raster timing, sync generation and blanked RGB output stage.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_generator #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        CLOCK_25,
  input  logic        RESET,
  input  logic [2:0]  color,
  input  logic        test_mode,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        video_on,
  output logic        frame_start,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic       run;
  logic       x_last;
  logic       y_last;
  logic       active;
  logic       hs_raw;
  logic       vs_raw;
  logic       fs_raw;
  logic [2:0] pix;

  // Idle one edge after reset so (0,0) is held and frame_start
  // lands on the second edge, keeping all outputs aligned.
  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) run <= 1'b0;
    else       run <= 1'b1;
  end

  assign x_last = (x == H_LAST);
  assign y_last = (y == V_LAST);

  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) begin
      x <= 12'd0;
      y <= 12'd0;
    end else if (run) begin
      if (x_last) begin
        x <= 12'd0;
        y <= y_last ? 12'd0 : y + 12'd1;
      end else begin
        x <= x + 12'd1;
      end
    end
  end

  assign active = (x < H_ACT) && (y < V_ACT);
  assign hs_raw = (x >= HS_BEG) && (x < HS_END);
  assign vs_raw = (y >= VS_BEG) && (y < VS_END);
  assign fs_raw = (x == 12'd0) && (y == 12'd0);

`ifdef VGA_TEST_PATTERN_EN
  localparam int          BAR_W    = H_ACTIVE / 8;
  localparam logic [6:0]  SUB_LAST = 7'(BAR_W - 1);

  logic [2:0] bar;
  logic [6:0] sub;

  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) begin
      bar <= 3'd0;
      sub <= 7'd0;
    end else if (run) begin
      if (x_last) begin
        bar <= 3'd0;
        sub <= 7'd0;
      end else if (x < H_ACT) begin
        if (sub == SUB_LAST) begin
          sub <= 7'd0;
          bar <= bar + 3'd1;
        end else begin
          sub <= sub + 7'd1;
        end
      end
    end
  end

  assign pix = test_mode ? bar : color;
`else
  logic unused_test_mode;

  assign unused_test_mode = test_mode;
  assign pix = color;
`endif

  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) begin
      VGA_HS      <= ~SYNC_POL;
      VGA_VS      <= ~SYNC_POL;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      VGA_R       <= 4'h0;
      VGA_G       <= 4'h0;
      VGA_B       <= 4'h0;
    end else if (run) begin
      VGA_HS      <= hs_raw ? SYNC_POL : ~SYNC_POL;
      VGA_VS      <= vs_raw ? SYNC_POL : ~SYNC_POL;
      video_on    <= active;
      frame_start <= fs_raw;
      VGA_R       <= active ? {4{pix[2]}} : 4'h0;
      VGA_G       <= active ? {4{pix[1]}} : 4'h0;
      VGA_B       <= active ? {4{pix[0]}} : 4'h0;
    end
  end

endmodule
